// File: rtl/par8_master.sv
// Initiator for the 8-bit parallel bus: turns byte write/read commands into bus_clk cycles,
// owns bus_rnw and turns bus_data around before the direction changes.
module par8_master #(
  parameter int HALF_CYCLES = 8,
  parameter int TURN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic [7:0] cmd_wdata,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       bus_clk,
  output logic       bus_rnw,
  output logic [7:0] bus_data_out,
  output logic       bus_data_oe,
  input  logic [7:0] bus_data_in
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    SETUP = 2'd2,
    HIGH  = 2'd3
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(HALF_CYCLES - 1);
  localparam logic [7:0] TURN_LAST = 8'(TURN_CYCLES - 1);

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic       bus_clk_r, bus_clk_s;
  logic       bus_rnw_r, bus_rnw_s;
  logic [7:0] data_out_r, data_out_s;
  logic       oe_r, oe_s;
  logic [7:0] rd_data_r, rd_data_s;
  logic       rd_valid_r, rd_valid_s;
  logic       ready_r, ready_s;
  logic       busy_r;
  logic       accept_s;

  // Next-state and next-output logic; every pin value is computed here and registered below.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r + 8'd1;
    bus_clk_s  = bus_clk_r;
    bus_rnw_s  = bus_rnw_r;
    data_out_s = data_out_r;
    oe_s       = oe_r;
    rd_data_s  = rd_data_r;
    rd_valid_s = 1'b0;
    accept_s   = (state_r == IDLE) && cmd_valid && ready_r;

    case (state_r)
      IDLE: begin
        cnt_s     = 8'd0;
        bus_clk_s = 1'b0;
        if (accept_s) begin
          data_out_s = cmd_wdata;
          if (cmd_rnw == bus_rnw_r) begin
            oe_s    = ~cmd_rnw;
            state_s = SETUP;
          end else begin
            // Direction flips: release the bus and wait out the turnaround first.
            bus_rnw_s = cmd_rnw;
            oe_s      = 1'b0;
            state_s   = TURN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      TURN: begin
        bus_clk_s = 1'b0;
        oe_s      = 1'b0;
        if (cnt_r == TURN_LAST) begin
          oe_s    = ~bus_rnw_r;
          cnt_s   = 8'd0;
          state_s = SETUP;
        end else begin
          state_s = TURN;
        end
      end
      SETUP: begin
        if (cnt_r == HALF_LAST) begin
          bus_clk_s = 1'b1;
          cnt_s     = 8'd0;
          state_s   = HIGH;
        end else begin
          bus_clk_s = 1'b0;
        end
      end
      HIGH: begin
        if (cnt_r == HALF_LAST) begin
          // Falling edge of bus_clk is also the read sample point.
          bus_clk_s = 1'b0;
          oe_s      = 1'b0;
          cnt_s     = 8'd0;
          state_s   = IDLE;
          if (bus_rnw_r) begin
            rd_data_s  = bus_data_in;
            rd_valid_s = 1'b1;
          end else begin
            rd_valid_s = 1'b0;
          end
        end else begin
          bus_clk_s = 1'b1;
        end
      end
      default: begin
        state_s   = IDLE;
        cnt_s     = 8'd0;
        bus_clk_s = 1'b0;
        oe_s      = 1'b0;
      end
    endcase

    ready_s = (state_s == IDLE);
  end

  // State, phase counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      bus_clk_r  <= 1'b0;
      bus_rnw_r  <= 1'b0;
      data_out_r <= 8'd0;
      oe_r       <= 1'b0;
      rd_data_r  <= 8'd0;
      rd_valid_r <= 1'b0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bus_clk_r  <= bus_clk_s;
      bus_rnw_r  <= bus_rnw_s;
      data_out_r <= data_out_s;
      oe_r       <= oe_s;
      rd_data_r  <= rd_data_s;
      rd_valid_r <= rd_valid_s;
      ready_r    <= ready_s;
      busy_r     <= ~ready_s;
    end
  end

  assign cmd_ready    = ready_r;
  assign busy         = busy_r;
  assign rd_data      = rd_data_r;
  assign rd_valid     = rd_valid_r;
  assign bus_clk      = bus_clk_r;
  assign bus_rnw      = bus_rnw_r;
  assign bus_data_out = data_out_r;
  assign bus_data_oe  = oe_r;

endmodule

// File: tb/tb_par8_master.sv
// Directed bench for par8_master with a behavioural bus slave and write/read scoreboards.
module tb_par8_master;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rnw = 1'b0;
  logic [7:0] cmd_wdata = 8'd0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       bus_clk;
  logic       bus_rnw;
  logic [7:0] bus_data_out;
  logic       bus_data_oe;
  logic [7:0] bus_data_in;

  int n_cmp = 0;
  int n_mis = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int tx_idx = 0;
  int rd_issued = 0;
  logic bus_clk_prev = 1'b0;
  logic [7:0] tx_mem [0:7];
  logic [7:0] exp_wr_q [$];
  logic [7:0] exp_rd_q [$];

  par8_master #(.HALF_CYCLES(8), .TURN_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rnw(cmd_rnw), .cmd_wdata(cmd_wdata), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .bus_clk(bus_clk), .bus_rnw(bus_rnw), .bus_data_out(bus_data_out),
    .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in)
  );

  always #5 clk = ~clk;

  assign bus_data_in = tx_mem[tx_idx];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model and scoreboards, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_clk && !bus_clk_prev && !bus_rnw) begin
        if (exp_wr_q.size() == 0) begin
          check("wr_unexpected", 32'(exp_wr_q.size()), 32'd1);
        end else begin
          check("wr_data", 32'(bus_data_out), 32'(exp_wr_q.pop_front()));
          check("wr_oe", 32'(bus_data_oe), 32'd1);
          wr_seen++;
        end
      end
      if (!bus_clk && bus_clk_prev && bus_rnw) tx_idx++;
      if (rd_valid) begin
        if (exp_rd_q.size() == 0) begin
          check("rd_unexpected", 32'(exp_rd_q.size()), 32'd1);
        end else begin
          check("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
          rd_seen++;
        end
      end
      check("oe_while_rnw", 32'(bus_data_oe & bus_rnw), 32'd0);
    end
    bus_clk_prev = bus_clk;
  end

  task automatic wait_ready(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (cmd_ready) break;
      @(posedge clk); #1;
    end
    check("ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic issue(input logic rnw, input logic [7:0] data, input logic push);
    wait_ready(200);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_wdata = data;
    if (push) begin
      if (rnw) begin
        exp_rd_q.push_back(tx_mem[rd_issued]);
        rd_issued++;
      end else begin
        exp_wr_q.push_back(data);
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic abort_mid_high(input logic rnw, input logic [7:0] data);
    issue(rnw, data, !rnw);
    for (int i = 0; i < 100; i++) begin
      if (bus_clk) break;
      @(posedge clk); #1;
    end
    check("abort_reach_high", 32'(bus_clk), 32'd1);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_clk", 32'(bus_clk), 32'd0);
    check("abort_oe", 32'(bus_data_oe), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check("release_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("release_ready", 32'(cmd_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    int wr_base;
    int rd_base;
    tx_mem[0] = 8'hA5; tx_mem[1] = 8'h5A; tx_mem[2] = 8'h00; tx_mem[3] = 8'hFF;
    tx_mem[4] = 8'h77; tx_mem[5] = 8'h00; tx_mem[6] = 8'h00; tx_mem[7] = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_bus_clk", 32'(bus_clk), 32'd0);
    check("rst_bus_rnw", 32'(bus_rnw), 32'd0);
    check("rst_data_out", 32'(bus_data_out), 32'd0);
    check("rst_oe", 32'(bus_data_oe), 32'd0);
    reset_n = 1'b1;
    #1 check("post_rst_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Single write timing
    cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_wdata = 8'h81;
    exp_wr_q.push_back(8'h81);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("tim_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      check("tim_bus_clk", 32'(bus_clk), 32'((k >= 8 && k < 16) ? 1 : 0));
      check("tim_ready", 32'(cmd_ready), 32'((k == 16) ? 1 : 0));
    end

    // Write -> read turnaround
    rd_base = rd_seen;
    check("turn_rnw_before", 32'(bus_rnw), 32'd0);
    cmd_valid = 1'b1; cmd_rnw = 1'b1;
    exp_rd_q.push_back(tx_mem[rd_issued]);
    rd_issued++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("turn_rnw_at_accept", 32'(bus_rnw), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      check("turn_oe", 32'(bus_data_oe), 32'd0);
      check("turn_bus_clk", 32'(bus_clk), 32'((k == 12) ? 1 : 0));
    end

    // Remaining reads from the slave's byte list
    for (int i = 0; i < 3; i++) issue(1'b1, 8'h00, 1'b1);
    wait_ready(200);
    repeat (2) @(posedge clk); #1;
    check("rd_count", 32'(rd_seen - rd_base), 32'd4);

    // Write every byte value
    wr_base = wr_seen;
    for (int v = 0; v < 256; v++) issue(1'b0, 8'(v), 1'b1);
    wait_ready(200);
    repeat (2) @(posedge clk); #1;
    check("wr_count", 32'(wr_seen - wr_base), 32'd256);

    // cmd_valid held with changing data: only the IDLE-cycle value goes out
    wr_base = wr_seen;
    cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_wdata = 8'h3C;
    exp_wr_q.push_back(8'h3C);
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) break;
      check("hold_busy", 32'(busy), 32'd1);
      cmd_wdata = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("hold_ready", 32'(cmd_ready), 32'd1);
    repeat (30) @(posedge clk); #1;
    check("hold_wr_count", 32'(wr_seen - wr_base), 32'd1);

    // Reset pulse in the middle of HIGH
    abort_mid_high(1'b0, 8'hC3);
    rd_base = rd_seen;
    abort_mid_high(1'b1, 8'h00);
    check("abort_no_rd_valid", 32'(rd_seen - rd_base), 32'd0);

    check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
